// File: rtl/pipe_ctrl.sv
// Pipeline hazard/halt controller: load-use stalls, branch flushes and a
// halt sequence that drains the pipe for DRAIN_CYC cycles before parking.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYC = 4,
  parameter logic [5:0]  HALT_OP   = 6'b010001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  if_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        br_taken,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        id_ex_bubble,
  output logic        flush_if_id,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        halted_q, halted_d;
  logic        lu_hazard;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu_hazard = ex_is_load && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    stall_cnt_d  = stall_cnt_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_hold = 1'b1;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (br_taken) begin
          flush_if_id  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu_hazard) begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (if_opcode == HALT_OP) begin
          drain_d = DRAIN_INIT;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A taken branch means the halt was fetched on the wrong path
        if (br_taken) begin
          flush_if_id  = 1'b1;
          id_ex_bubble = 1'b1;
          drain_d      = 4'd0;
          state_d      = S_RUN;
        end else begin
          pc_hold     = 1'b1;
          flush_if_id = 1'b1;
          drain_d     = drain_q - 4'd1;
          if (drain_q == 4'd1) state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        pc_hold     = 1'b1;
        flush_if_id = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_q     <= 4'd0;
      stall_cnt_q <= 16'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule
